// File: rtl/tnn_feature_packer.sv
// tnn_feature_packer
// Quantizes a stream of raw features to 3 bits each and packs six of them into
// one vector for the 6-input ternary-neuron cores. While one vector is held on
// the output, the next sample can be assembled. A second completed vector can
// wait in the assembly buffer until the output is free.
module tnn_feature_packer #(
  parameter int RAW_W  = 8,
  parameter int OFFSET = 0,
  parameter int SHIFT  = 5,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [RAW_W-1:0] s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [2:0]       feat_a,
  output logic [2:0]       feat_b,
  output logic [2:0]       feat_c,
  output logic [2:0]       feat_d,
  output logic [2:0]       feat_e,
  output logic [2:0]       feat_f,
  output logic             err_short,
  output logic             err_long,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [0:0] COLLECT = 1'b0;  // filling slots 0..5
  localparam logic [0:0] DROP    = 1'b1;  // discarding surplus beats of an overlong sample

  localparam logic [RAW_W-1:0] OFF_V = RAW_W'(OFFSET);
  localparam logic [RAW_W-1:0] SAT_V = RAW_W'(7);

  logic [0:0]       state;
  logic [2:0]       idx;
  logic [2:0]       asm_q [6];   // assembly buffer; also holds the pending vector
  logic [2:0]       out_q [6];   // output register
  logic             pend;        // asm_q holds a complete vector not yet handed off

  logic [RAW_W-1:0] diff;
  logic [RAW_W-1:0] shifted;
  logic [2:0]       q;
  logic             accept;
  logic             out_free;
  logic             complete;
  logic             short_ev;
  logic             long_ev;
  logic [2:0]       next_vec [6];

  assign s_ready  = !pend;
  assign accept   = s_valid && s_ready;
  assign out_free = !m_valid || m_ready;

  assign feat_a = out_q[0];
  assign feat_b = out_q[1];
  assign feat_c = out_q[2];
  assign feat_d = out_q[3];
  assign feat_e = out_q[4];
  assign feat_f = out_q[5];

  // Quantize the incoming beat: subtract offset clamped at 0, shift, saturate at 7.
  always_comb begin
    diff    = (s_data >= OFF_V) ? (s_data - OFF_V) : '0;
    shifted = diff >> SHIFT;
    q       = (shifted > SAT_V) ? 3'd7 : shifted[2:0];
  end

  // Work out the vector as it stands after this beat and whether it closes a sample.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    next_vec = asm_q;
    complete = 1'b0;
    short_ev = 1'b0;
    long_ev  = 1'b0;
    if (accept && state == COLLECT) begin
      for (int i = 0; i < 6; i++) begin
        if (3'(i) == idx)                next_vec[i] = q;
        else if (3'(i) > idx && s_last)  next_vec[i] = 3'd0;
      end
      if (s_last) begin
        complete = 1'b1;
        short_ev = (idx != 3'd5);
      end else if (idx == 3'd5) begin
        complete = 1'b1;
        long_ev  = 1'b1;
      end
    end
  end

  // Sample framing: slot index and COLLECT/DROP state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignment so all registers update together.
      state <= COLLECT;
      idx   <= 3'd0;
    end else if (accept) begin
      if (state == COLLECT) begin
        if (complete) idx <= 3'd0;
        else          idx <= idx + 3'd1;
        if (long_ev)  state <= DROP;
      end else if (s_last) begin
        state <= COLLECT;
      end
    end
  end

  // Assembly buffer, pending flag and output register handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the small vector buffers are reset because their zero state is visible on feat_*.
      for (int i = 0; i < 6; i++) begin
        asm_q[i] <= 3'd0;
        out_q[i] <= 3'd0;
      end
      pend    <= 1'b0;
      m_valid <= 1'b0;
    end else begin
      asm_q <= next_vec;
      if (pend && out_free) begin
        out_q   <= asm_q;
        m_valid <= 1'b1;
        pend    <= 1'b0;
      end else if (complete && out_free) begin
        out_q   <= next_vec;
        m_valid <= 1'b1;
      end else if (complete) begin
        pend    <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  // Error pulses and event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_short <= 1'b0;
      err_long  <= 1'b0;
      vec_cnt   <= '0;
      err_cnt   <= '0;
    end else begin
      err_short <= short_ev;
      err_long  <= long_ev;
      if (m_valid && m_ready) vec_cnt <= vec_cnt + 1'b1;
      if ((short_ev || long_ev) && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule
